// File: rtl/vjtag_pkg.sv
// vjtag_pkg: shared IR codes, DR lengths, ID default and STATUS bit positions
package vjtag_pkg;
    localparam logic [3:0] IR_BYPASS = 4'd0;
    localparam logic [3:0] IR_IDCODE = 4'd1;
    localparam logic [3:0] IR_WRITE  = 4'd2;
    localparam logic [3:0] IR_READ   = 4'd3;
    localparam logic [3:0] IR_STATUS = 4'd4;
    localparam logic [31:0] ID_VALUE_DEF = 32'h4C41_5631;
    localparam int ST_ONE        = 0;
    localparam int ST_WR_PENDING = 1;
    localparam int ST_RD_VALID   = 2;
    localparam int ST_OVERFLOW   = 3;
    function automatic logic [5:0] dr_len(input logic [3:0] ir, input int data_w);
        return ir == IR_IDCODE ? 6'd32 :
               (ir == IR_WRITE || ir == IR_READ) ? 6'(data_w) :
               ir == IR_STATUS ? 6'd4 : 6'd1;
    endfunction
endpackage

// File: rtl/vjtag_shift_reg.sv
// vjtag_shift_reg: variable-length LSB-first DR, bits at and above len kept zero
module vjtag_shift_reg (
    input  logic        tck,
    input  logic        rst,
    input  logic [5:0]  len,
    input  logic [31:0] cap_val,
    input  logic        cdr,
    input  logic        sdr,
    input  logic        tdi,
    output logic [31:0] sr
);
    logic [31:0] mask;
    assign mask = 32'hFFFF_FFFF >> (6'd32 - len);
    // capture wins over shift; tdi enters at the top of the active length
    always_ff @(posedge tck or posedge rst) begin
        if (rst)
            sr <= '0;
        else if (cdr)
            sr <= cap_val & mask;
        else if (sdr)
            sr <= (sr >> 1) | ({31'd0, tdi} << (len - 6'd1));
    end
endmodule

// File: rtl/vjtag_dr_responder.sv
// vjtag_dr_responder: virtual JTAG user DR decoder with ID, write and read channels
module vjtag_dr_responder
    import vjtag_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic              tck,
    input  logic              rst,
    input  logic              tdi,
    input  logic [3:0]        ir_in,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_uir,
    output logic              tdo,
    output logic [3:0]        ir_out,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              rd_ack
);
    logic [3:0]  active_ir;
    logic [31:0] sr;
    logic [31:0] cap_val;
    logic [5:0]  len;
    logic [3:0]  status;
    logic        overflow;
    logic        wr_pending;
    logic        rd_taken;
    logic        upd;
    logic        unused_sr;

    assign status    = {overflow, rd_valid, wr_pending, 1'b1};
    assign len       = dr_len(active_ir, DATA_W);
    assign upd       = virtual_state_udr & ~virtual_state_cdr;
    assign tdo       = sr[0];
    assign unused_sr = ^sr;

    // capture value for the selected instruction, zero-extended to 32 bits
    always_comb begin
        cap_val = '0;
        cap_val = active_ir == IR_IDCODE ? ID_VALUE :
                  active_ir == IR_WRITE  ? 32'(wr_data) :
                  active_ir == IR_READ   ? (rd_valid ? 32'(rd_data) : 32'd0) :
                  active_ir == IR_STATUS ? 32'(status) : 32'd0;
    end

    vjtag_shift_reg u_sr (
        .tck     (tck),
        .rst     (rst),
        .len     (len),
        .cap_val (cap_val),
        .cdr     (virtual_state_cdr),
        .sdr     (virtual_state_sdr & ~virtual_state_udr),
        .tdi     (tdi),
        .sr      (sr)
    );

    // instruction latch, only moves on update-IR
    always_ff @(posedge tck or posedge rst) begin
        if (rst)
            active_ir <= IR_BYPASS;
        else if (virtual_state_uir)
            active_ir <= ir_in;
    end

    // update decode, single-cycle pulses and sticky status flags
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            wr_data    <= '0;
            wr_valid   <= 1'b0;
            rd_ack     <= 1'b0;
            overflow   <= 1'b0;
            wr_pending <= 1'b0;
            rd_taken   <= 1'b0;
            ir_out     <= '0;
        end else begin
            wr_valid <= 1'b0;
            rd_ack   <= 1'b0;
            ir_out   <= status;
            if (virtual_state_cdr && active_ir == IR_READ)
                rd_taken <= rd_valid;
            if (upd && active_ir == IR_WRITE) begin
                wr_data    <= sr[DATA_W-1:0];
                wr_valid   <= 1'b1;
                wr_pending <= 1'b1;
            end
            if (upd && active_ir == IR_READ) begin
                if (rd_taken) begin
                    rd_ack   <= 1'b1;
                    rd_taken <= 1'b0;
                end else
                    overflow <= 1'b1;
            end
            if (upd && active_ir == IR_STATUS) begin
                if (sr[ST_OVERFLOW])
                    overflow <= 1'b0;
                if (sr[ST_WR_PENDING])
                    wr_pending <= 1'b0;
            end
        end
    end
endmodule
